// File: rtl/fft16_bitrev_reorder.sv
// fft16_bitrev_reorder
//   Output reorder stage for the 16-point radix-2 FFT. The core emits every
//   frame in bit-reversed bin order. This block writes each frame into one bank
//   of a ping-pong buffer at the bit-reversed address and reads it back in
//   natural order (bin 0..N-1). One bank fills while the other drains, so the
//   block sustains one sample in and one sample out per cycle.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bypass     (only with REORDER_BYPASS_EN) natural-order write addressing;
//              sampled on the first accepted sample of a frame, held for it
//   in_valid   input sample valid
//   in_ready   input can be accepted (transfer on in_valid && in_ready)
//   in_r/in_i  input real/imag words, bit-reversed frame order
//   out_valid  output sample valid
//   out_ready  downstream accepts (transfer on out_valid && out_ready)
//   out_r/i    output real/imag words, natural order, unmodified
//   out_last   high with the bin N-1 word
//   out_idx    bin index of the current output word
//
// Configuration
//   REORDER_BYPASS_EN  when defined, adds the bypass port described above.
module fft16_bitrev_reorder #(
    parameter int DATA_WIDTH = 12,
    parameter int N          = 16,
    parameter int LOG2N      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
`ifdef REORDER_BYPASS_EN
    input  logic                         bypass,
`endif
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_r,
    input  logic signed [DATA_WIDTH-1:0] in_i,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_r,
    output logic signed [DATA_WIDTH-1:0] out_i,
    output logic                         out_last,
    output logic [LOG2N-1:0]             out_idx
);

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = a[LOG2N-1-b];
        end
        return r;
    endfunction

    logic signed [DATA_WIDTH-1:0] mem_r [2][N];
    logic signed [DATA_WIDTH-1:0] mem_i [2][N];

    logic [LOG2N-1:0] wr_cnt;
    logic [LOG2N-1:0] rd_cnt;
    logic             wr_bank;
    logic             rd_bank;
    logic [1:0]       full;

    logic             wr_fire;
    logic             wr_done;
    logic             rd_load;
    logic             rd_done;
    logic [LOG2N-1:0] wr_addr;
    logic [1:0]       set_mask;
    logic [1:0]       clr_mask;

    // A full bank is never written: in_ready gates every write.
    assign in_ready = !full[wr_bank];
    assign wr_fire  = in_valid && in_ready;
    assign wr_done  = wr_fire && (wr_cnt == LOG2N'(N-1));
    assign rd_load  = (!out_valid || out_ready) && full[rd_bank];
    assign rd_done  = rd_load && (rd_cnt == LOG2N'(N-1));

`ifdef REORDER_BYPASS_EN
    logic frame_bypass;
    logic bypass_eff;

    // The first sample of a frame uses the live bypass pin; the rest of the
    // frame uses the value captured with that first sample.
    assign bypass_eff = (wr_cnt == '0) ? bypass : frame_bypass;
    assign wr_addr    = bypass_eff ? wr_cnt : bitrev(wr_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_bypass <= 1'b0;
        end else if (wr_fire && (wr_cnt == '0)) begin
            frame_bypass <= bypass;
        end
    end
`else
    assign wr_addr = bitrev(wr_cnt);
`endif

    // Write stage: frame storage, no reset on data.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_r[wr_bank][wr_addr] <= in_r;
            mem_i[wr_bank][wr_addr] <= in_i;
        end
    end

    // Release and refill can happen on the same edge; they always target
    // different banks, so both updates are applied together.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (wr_done) begin
            set_mask[wr_bank] = 1'b1;
        end
        if (rd_done) begin
            clr_mask[rd_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            full    <= '0;
        end else begin
            full <= (full | set_mask) & ~clr_mask;
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_done) begin
                    wr_bank <= !wr_bank;
                end
            end
        end
    end

    // Read stage: natural-order output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            out_r     <= '0;
            out_i     <= '0;
        end else if (rd_load) begin
            out_valid <= 1'b1;
            out_r     <= mem_r[rd_bank][rd_cnt];
            out_i     <= mem_i[rd_bank][rd_cnt];
            out_idx   <= rd_cnt;
            out_last  <= (rd_cnt == LOG2N'(N-1));
            rd_cnt    <= rd_cnt + 1'b1;
            if (rd_done) begin
                rd_bank <= !rd_bank;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft16_bitrev_reorder.sv
module tb_fft16_bitrev_reorder;
    localparam int DW = 12;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_r;
    logic signed [DW-1:0] in_i;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_r;
    logic signed [DW-1:0] out_i;
    logic                 out_last;
    logic [3:0]           out_idx;
`ifdef REORDER_BYPASS_EN
    logic                 bypass;
`endif

    always #5 clk = ~clk;

    fft16_bitrev_reorder #(.DATA_WIDTH(DW), .N(16), .LOG2N(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef REORDER_BYPASS_EN
        .bypass(bypass),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_r(in_r),
        .in_i(in_i),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_r(out_r),
        .out_i(out_i),
        .out_last(out_last),
        .out_idx(out_idx)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic signed [DW-1:0] r;
        logic signed [DW-1:0] i;
        int                   idx;
    } exp_t;

    // Reference model: collect a whole frame in arrival order, then emit it
    // in natural bin order. Arrival k carries bin rev4(k), so bin n is the
    // sample that arrived at position rev4(n).
    exp_t                 expq[$];
    logic signed [DW-1:0] fr_r[16];
    logic signed [DW-1:0] fr_i[16];
    int                   fr_cnt = 0;
    bit                   fr_byp = 1'b0;
    bit                   drv_bypass = 1'b0;

    function automatic int rev4(input int n);
        return ((n % 2) * 8) + (((n / 2) % 2) * 4) + (((n / 4) % 2) * 2) + ((n / 8) % 2);
    endfunction

    task automatic model_accept(input logic signed [DW-1:0] dr, input logic signed [DW-1:0] di);
        exp_t e;
        int   src;
        if (fr_cnt == 0) fr_byp = drv_bypass;
        fr_r[fr_cnt] = dr;
        fr_i[fr_cnt] = di;
        fr_cnt++;
        if (fr_cnt == 16) begin
            for (int n = 0; n < 16; n++) begin
                src   = fr_byp ? n : rev4(n);
                e.r   = fr_r[src];
                e.i   = fr_i[src];
                e.idx = n;
                expq.push_back(e);
            end
            fr_cnt = 0;
        end
    endtask

    task automatic model_reset();
        fr_cnt = 0;
        expq.delete();
    endtask

    // One clock cycle: drive at the falling edge, sample 1 time unit later,
    // and report which handshakes will complete at the next rising edge.
    task automatic cycle(input bit iv, input logic signed [DW-1:0] dr, input logic signed [DW-1:0] di,
                         input bit ordy, output bit ifire, output bit ofire);
        @(negedge clk);
        in_valid  = iv;
        in_r      = dr;
        in_i      = di;
        out_ready = ordy;
`ifdef REORDER_BYPASS_EN
        bypass    = drv_bypass;
`endif
        #1;
        ifire = iv && (in_ready === 1'b1);
        ofire = (out_valid === 1'b1) && ordy;
        if (ifire) model_accept(dr, di);
    endtask

    function automatic logic signed [DW-1:0] rnd12();
        logic [31:0] t;
        t = $urandom;
        return t[DW-1:0];
    endfunction

    task automatic test_reset();
        bit fi, fo;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_r       = '0;
        in_i       = '0;
        drv_bypass = 1'b0;
`ifdef REORDER_BYPASS_EN
        bypass     = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) begin
            cycle(1'b0, '0, '0, 1'b1, fi, fo);
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_r !== '0 || out_i !== '0 ||
                out_last !== 1'b0 || out_idx !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_idle got valid=%b ready=%b r=%0d i=%0d last=%b idx=%0d want 0 1 0 0 0 0",
                         out_valid, in_ready, out_r, out_i, out_last, out_idx);
            end
        end
        // Load one full frame plus part of the next, then reset mid-frame.
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, DW'(k + 1), -DW'(k + 1), 1'b0, fi, fo);
        end
        cycle(1'b0, '0, '0, 1'b0, fi, fo);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_valid got %b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_r !== '0 || out_i !== '0 ||
            out_last !== 1'b0 || out_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset got valid=%b ready=%b r=%0d i=%0d last=%b idx=%0d want 0 1 0 0 0 0",
                     out_valid, in_ready, out_r, out_i, out_last, out_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_frame();
        bit                   fi, fo;
        int                   acc = 0, got = 0, cyc = 0, acc_cyc = -1;
        logic signed [DW-1:0] dr, di, wr, wi;
        exp_t                 e;
        while (got < 16 && cyc < 100) begin
            dr = DW'(rev4(acc % 16) * 16);
            di = -dr;
            cycle(acc < 16, dr, di, 1'b1, fi, fo);
            if (acc_cyc >= 0 && cyc == acc_cyc + 1) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_latency_early got valid=%b want 0", out_valid);
                end
            end
            if (acc_cyc >= 0 && cyc == acc_cyc + 2) begin
                n_checks++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_latency_first got valid=%b want 1", out_valid);
                end
            end
            if (fo) begin
                wr = DW'(got * 16);
                wi = -wr;
                n_checks++;
                if (out_r !== wr || out_i !== wi || out_idx !== 4'(got) || out_last !== (got == 15)) begin
                    n_fail++;
                    $display("FAIL single_out got r=%0d i=%0d idx=%0d last=%b want r=%0d i=%0d idx=%0d last=%b",
                             out_r, out_i, out_idx, out_last, wr, wi, got, (got == 15));
                end
                if (expq.size() > 0) e = expq.pop_front();
                got++;
            end
            if (fi) begin
                acc++;
                if (acc == 16) acc_cyc = cyc;
            end
            cyc++;
        end
        if (got < 16) begin
            n_checks++;
            n_fail++;
            $display("FAIL single_timeout got %0d outputs want 16", got);
        end
    endtask

    task automatic test_back_to_back();
        bit                   fi, fo, iv;
        int                   sent = 0, got = 0, cyc = 0;
        logic signed [DW-1:0] dr, di;
        exp_t                 e;
        while (got < 64 && cyc < 300) begin
            iv = (sent < 64);
            dr = rnd12();
            di = rnd12();
            cycle(iv, dr, di, 1'b1, fi, fo);
            if (iv) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_in_ready at sample %0d got %b want 1", sent, in_ready);
                end
            end
            if (got > 0 && got < 64) begin
                n_checks++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_contiguous after %0d outputs got valid=%b want 1", got, out_valid);
                end
            end
            if (fo) begin
                n_checks++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_out unexpected output r=%0d want none", out_r);
                end else begin
                    e = expq.pop_front();
                    if (out_r !== e.r || out_i !== e.i || out_idx !== 4'(e.idx) || out_last !== (e.idx == 15)) begin
                        n_fail++;
                        $display("FAIL b2b_out got r=%0d i=%0d idx=%0d last=%b want r=%0d i=%0d idx=%0d last=%b",
                                 out_r, out_i, out_idx, out_last, e.r, e.i, e.idx, (e.idx == 15));
                    end
                end
                got++;
            end
            if (fi) sent++;
            cyc++;
        end
        n_checks++;
        if (got != 64 || expq.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count got %0d outputs pending %0d want 64 and 0", got, expq.size());
        end
    endtask

    task automatic test_backpressure();
        bit                   fi, fo, iv, drop_seen = 1'b0, have_hold = 1'b0;
        int                   sent = 0, got = 0, cyc = 0;
        logic signed [DW-1:0] dr, di, h_r, h_i;
        logic [3:0]           h_idx;
        exp_t                 e;
        for (int c = 0; c < 40; c++) begin
            iv = (sent < 48);
            dr = rnd12();
            di = rnd12();
            cycle(iv, dr, di, 1'b0, fi, fo);
            if (!drop_seen && iv && in_ready === 1'b0) begin
                drop_seen = 1'b1;
                n_checks++;
                if (sent != 32) begin
                    n_fail++;
                    $display("FAIL bp_drop_point got %0d accepts want 32", sent);
                end
            end
            if (have_hold) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_r !== h_r || out_i !== h_i || out_idx !== h_idx) begin
                    n_fail++;
                    $display("FAIL bp_stall_hold got valid=%b r=%0d i=%0d idx=%0d want 1 r=%0d i=%0d idx=%0d",
                             out_valid, out_r, out_i, out_idx, h_r, h_i, h_idx);
                end
            end else if (out_valid === 1'b1) begin
                have_hold = 1'b1;
                h_r = out_r;
                h_i = out_i;
                h_idx = out_idx;
            end
            if (fi) sent++;
        end
        n_checks++;
        if (!drop_seen || !have_hold) begin
            n_fail++;
            $display("FAIL bp_stall_state got drop=%b valid_seen=%b want 1 1", drop_seen, have_hold);
        end
        while (got < 48 && cyc < 300) begin
            iv = (sent < 48);
            dr = rnd12();
            di = rnd12();
            cycle(iv, dr, di, 1'b1, fi, fo);
            if (fo) begin
                n_checks++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_out unexpected output r=%0d want none", out_r);
                end else begin
                    e = expq.pop_front();
                    if (out_r !== e.r || out_i !== e.i || out_idx !== 4'(e.idx) || out_last !== (e.idx == 15)) begin
                        n_fail++;
                        $display("FAIL bp_out got r=%0d i=%0d idx=%0d last=%b want r=%0d i=%0d idx=%0d last=%b",
                                 out_r, out_i, out_idx, out_last, e.r, e.i, e.idx, (e.idx == 15));
                    end
                    if (got < 16) begin
                        n_checks++;
                        if (in_ready !== (e.idx == 15)) begin
                            n_fail++;
                            $display("FAIL bp_release at bin %0d got in_ready=%b want %b", e.idx, in_ready, (e.idx == 15));
                        end
                    end
                end
                got++;
            end
            if (fi) sent++;
            cyc++;
        end
        n_checks++;
        if (got != 48 || sent != 48 || expq.size() != 0) begin
            n_fail++;
            $display("FAIL bp_count got out=%0d in=%0d pending=%0d want 48 48 0", got, sent, expq.size());
        end
    endtask

    task automatic test_random();
        bit                   fi, fo, iv, ordy, stalled = 1'b0;
        int                   sent = 0, got = 0, cyc = 0;
        logic signed [DW-1:0] dr, di, h_r, h_i;
        logic [3:0]           h_idx;
        logic                 h_last;
        exp_t                 e;
        while ((got < 320 || sent < 320) && cyc < 4000) begin
            iv   = (sent < 320) && ($urandom % 2 == 1);
            ordy = ($urandom % 2 == 1);
            dr   = rnd12();
            di   = rnd12();
            cycle(iv, dr, di, ordy, fi, fo);
            if (stalled) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_r !== h_r || out_i !== h_i || out_idx !== h_idx || out_last !== h_last) begin
                    n_fail++;
                    $display("FAIL rand_hold got valid=%b r=%0d i=%0d idx=%0d want 1 r=%0d i=%0d idx=%0d",
                             out_valid, out_r, out_i, out_idx, h_r, h_i, h_idx);
                end
            end
            stalled = (out_valid === 1'b1) && !ordy;
            h_r = out_r;
            h_i = out_i;
            h_idx = out_idx;
            h_last = out_last;
            if (fo) begin
                n_checks++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_out unexpected output r=%0d want none", out_r);
                end else begin
                    e = expq.pop_front();
                    if (out_r !== e.r || out_i !== e.i || out_idx !== 4'(e.idx) || out_last !== (e.idx == 15)) begin
                        n_fail++;
                        $display("FAIL rand_out got r=%0d i=%0d idx=%0d last=%b want r=%0d i=%0d idx=%0d last=%b",
                                 out_r, out_i, out_idx, out_last, e.r, e.i, e.idx, (e.idx == 15));
                    end
                end
                got++;
            end
            if (fi) sent++;
            cyc++;
        end
        n_checks++;
        if (got != 320 || sent != 320 || expq.size() != 0) begin
            n_fail++;
            $display("FAIL rand_count got out=%0d in=%0d pending=%0d want 320 320 0", got, sent, expq.size());
        end
    endtask

`ifdef REORDER_BYPASS_EN
    task automatic test_bypass();
        bit                   fi, fo, iv;
        int                   sent = 0, got = 0, cyc = 0, f, n;
        logic signed [DW-1:0] dr, want;
        exp_t                 e;
        while (got < 48 && cyc < 300) begin
            iv = (sent < 48);
            // Frame 0 bypass, frame 1 bit-reversed, frame 2 starts in bypass
            // and toggles the pin on every later sample.
            if (sent < 16)      drv_bypass = 1'b1;
            else if (sent < 32) drv_bypass = 1'b0;
            else                drv_bypass = (sent % 2 == 0);
            dr = DW'(sent);
            cycle(iv, dr, -dr, 1'b1, fi, fo);
            if (fo) begin
                f = got / 16;
                n = got % 16;
                want = (f == 1) ? DW'(16 + rev4(n)) : DW'(got);
                n_checks++;
                if (out_r !== want || out_i !== -want || out_idx !== 4'(n)) begin
                    n_fail++;
                    $display("FAIL bypass_out frame %0d got r=%0d i=%0d idx=%0d want r=%0d i=%0d idx=%0d",
                             f, out_r, out_i, out_idx, want, -want, n);
                end
                if (expq.size() > 0) e = expq.pop_front();
                got++;
            end
            if (fi) sent++;
            cyc++;
        end
        drv_bypass = 1'b0;
        n_checks++;
        if (got != 48) begin
            n_fail++;
            $display("FAIL bypass_count got %0d want 48", got);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_random();
`ifdef REORDER_BYPASS_EN
        test_bypass();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
